// File: rtl/branch_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage branch controller:
// branch condition codes, controller state encoding and sizing constants.
package branch_ctrl_pkg;

   localparam int DATA_W     = 16;
   localparam int WAIT_MAX   = 15;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_LT   = 2'b01,
      OP_EQ   = 2'b10,
      OP_GT   = 2'b11
   } br_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_EVAL  = 2'b10,
      ST_FLUSH = 2'b11
   } br_state_e;

   // Saturating +1 for event counters that must never wrap back to zero.
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + DATA_W'(1);
   endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Branch condition evaluation: signs of the wrapped difference a - b decide
// GT/LT/EQ, with no overflow correction.
module branch_cmp
   import branch_ctrl_pkg::*;
(
   input  br_op_e            op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              taken
);

   logic [DATA_W-1:0] diff;
   logic              zero;
   logic              neg;

   assign diff = a - b;
   assign zero = (diff == '0);
   assign neg  = diff[DATA_W-1];

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_GT:   taken = !neg && !zero;
         OP_LT:   taken = neg;
         OP_EQ:   taken = zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: stalls the front end while operands settle,
// evaluates the condition, and redirects/flushes on a taken branch.
module branch_ctrl
   import branch_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              br_valid,
   input  logic [1:0]        br_op,
   input  logic [DATA_W-1:0] br_target,
   input  logic [DATA_W-1:0] reg_a,
   input  logic [DATA_W-1:0] reg15,
   input  logic              opnd_ready,
   output logic              stall_id,
   output logic              flush_ifid,
   output logic              pc_load,
   output logic [DATA_W-1:0] pc_target,
   output logic [DATA_W-1:0] taken_cnt,
   output logic              wait_err
);

   br_state_e             state_q, state_d;
   br_op_e                op_q, op_d;
   logic [DATA_W-1:0]     target_q, target_d;
   logic [DATA_W-1:0]     taken_cnt_q, taken_cnt_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  wait_err_q, wait_err_d;

   logic accept;
   logic timeout;
   logic taken;

   assign accept  = br_valid && (br_op_e'(br_op) != OP_NONE);
   // Fires on the WAIT cycle whose increment brings the counter to WAIT_MAX.
   assign timeout = (wait_cnt_q == WAIT_CNT_W'(WAIT_MAX - 1)) && !opnd_ready;

   branch_cmp u_cmp (
      .op    (op_q),
      .a     (reg_a),
      .b     (reg15),
      .taken (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = opnd_ready ? ST_EVAL : ST_WAIT;
         ST_WAIT: begin
            if (opnd_ready)   state_d = ST_EVAL;
            else if (timeout) state_d = ST_IDLE;
         end
         ST_EVAL:  state_d = taken ? ST_FLUSH : ST_IDLE;
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are forced low while rst is held, whatever state is current.
   always_comb begin
      stall_id   = 1'b0;
      flush_ifid = 1'b0;
      pc_load    = 1'b0;
      pc_target  = '0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: stall_id = accept;
            ST_WAIT: stall_id = 1'b1;
            ST_EVAL: begin
               stall_id = 1'b1;
               if (taken) begin
                  pc_load    = 1'b1;
                  flush_ifid = 1'b1;
                  pc_target  = target_q;
               end
            end
            ST_FLUSH: flush_ifid = 1'b1;
            default: ;
         endcase
      end
   end

   assign taken_cnt = rst ? '0 : taken_cnt_q;
   assign wait_err  = !rst && wait_err_q;

   always_comb begin
      op_d        = op_q;
      target_d    = target_q;
      wait_cnt_d  = wait_cnt_q;
      taken_cnt_d = taken_cnt_q;
      wait_err_d  = wait_err_q;
      if (state_q == ST_IDLE && accept) begin
         op_d     = br_op_e'(br_op);
         target_d = br_target;
      end
      if (state_q == ST_WAIT)      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
      else if (state_d == ST_WAIT) wait_cnt_d = '0;
      if (pc_load) taken_cnt_d = sat_inc(taken_cnt_q);
      if (state_q == ST_WAIT && timeout) wait_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= OP_NONE;
         target_q    <= '0;
         wait_cnt_q  <= '0;
         taken_cnt_q <= '0;
         wait_err_q  <= 1'b0;
      end else begin
         op_q        <= op_d;
         target_q    <= target_d;
         wait_cnt_q  <= wait_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         wait_err_q  <= wait_err_d;
      end
   end

   a_pcl_pulse : assert property (@(posedge clk) disable iff (rst) pc_load |=> !pc_load);
   a_tgt_quiet : assert property (@(posedge clk) disable iff (rst) !pc_load |-> pc_target == '0);
   a_flush_nostall : assert property (@(posedge clk) disable iff (rst)
                                      state_q == ST_FLUSH |-> !stall_id);

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl: each branch transaction is
// expanded into its expected per-cycle output timeline, checked by a monitor.
module tb_branch_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, br_valid, opnd_ready;
   logic [1:0]   br_op;
   logic [W-1:0] br_target, reg_a, reg15;
   logic         stall_id, flush_ifid, pc_load, wait_err;
   logic [W-1:0] pc_target, taken_cnt;

   typedef struct packed {
      logic         stall;
      logic         flush;
      logic         pcl;
      logic [W-1:0] tgt;
      logic [W-1:0] cnt;
      logic         werr;
   } obs_t;

   obs_t        exp_q[$];
   string       tag_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned m_cnt;
   bit          m_werr;

   obs_t  mon_a, mon_e;
   string mon_t;

   always #5 clk = ~clk;

   branch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .br_valid   (br_valid),
      .br_op      (br_op),
      .br_target  (br_target),
      .reg_a      (reg_a),
      .reg15      (reg15),
      .opnd_ready (opnd_ready),
      .stall_id   (stall_id),
      .flush_ifid (flush_ifid),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .taken_cnt  (taken_cnt),
      .wait_err   (wait_err)
   );

   // Reference decision: sign of the 16-bit wrapped difference.
   function automatic bit ref_taken(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      int ai, bi, d;
      ai = a;
      bi = b;
      d  = (ai - bi) & 'hFFFF;
      case (op)
         2'b11:   return (d != 0) && (d < 'h8000);
         2'b01:   return d >= 'h8000;
         2'b10:   return d == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic obs_t mk(input bit s, input bit f, input bit p, input logic [W-1:0] t);
      return {s, f, p, t, m_cnt[W-1:0], m_werr};
   endfunction

   task automatic step(input obs_t e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic junk();
      br_valid   = 1'($urandom_range(0, 1));
      br_op      = 2'($urandom);
      br_target  = W'($urandom);
      reg_a      = W'($urandom);
      reg15      = W'($urandom);
      opnd_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle_cyc();
      junk();
      if (br_valid) br_op = 2'b00;
      step(mk(0, 0, 0, '0), "idle");
   endtask

   task automatic rst_cyc(input string t);
      junk();
      rst    = 1'b1;
      m_cnt  = 0;
      m_werr = 1'b0;
      step(mk(0, 0, 0, '0), {t, "_rst"});
      rst = 1'b0;
   endtask

   // d = WAIT cycles before operands are ready (>15 means never); rst_at =
   // cycle index within the transaction at which reset hits (-1 = none).
   task automatic branch(input logic [1:0] op, input logic [W-1:0] tgt,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int d, input int rst_at, input string t);
      bit tmo, tk;
      int nwait, cyc;
      tmo   = d > 15;
      nwait = tmo ? 15 : d;
      tk    = !tmo && ref_taken(op, a, b);
      cyc   = 0;
      if (rst_at == cyc) begin rst_cyc(t); return; end
      junk();
      br_valid   = 1'b1;
      br_op      = op;
      br_target  = tgt;
      opnd_ready = (d == 0);
      step(mk(1, 0, 0, '0), {t, "_acc"});
      cyc++;
      for (int k = 0; k < nwait; k++) begin
         if (rst_at == cyc) begin rst_cyc(t); return; end
         junk();
         opnd_ready = !tmo && (k == nwait - 1);
         step(mk(1, 0, 0, '0), {t, "_wait"});
         cyc++;
      end
      if (tmo) begin m_werr = 1'b1; return; end
      if (rst_at == cyc) begin rst_cyc(t); return; end
      junk();
      reg_a = a;
      reg15 = b;
      step(mk(1, tk, tk, tk ? tgt : '0), {t, "_eval"});
      cyc++;
      if (!tk) return;
      if (m_cnt < 'hFFFF) m_cnt++;
      if (rst_at == cyc) begin rst_cyc(t); return; end
      junk();
      step(mk(0, 1, 0, '0), {t, "_flush"});
   endtask

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] tbl [5];
      tbl = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      return tbl[$urandom_range(0, 4)];
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_a = {stall_id, flush_ifid, pc_load, pc_target, taken_cnt, wait_err};
         mon_e = exp_q.pop_front();
         mon_t = tag_q.pop_front();
         n_cmp++;
         if (mon_a !== mon_e) begin
            n_err++;
            $display("FAIL %s @%0t: got stall=%0b flush=%0b pcl=%0b tgt=%h cnt=%h werr=%0b, want stall=%0b flush=%0b pcl=%0b tgt=%h cnt=%h werr=%0b",
                     mon_t, $time, mon_a.stall, mon_a.flush, mon_a.pcl, mon_a.tgt, mon_a.cnt, mon_a.werr,
                     mon_e.stall, mon_e.flush, mon_e.pcl, mon_e.tgt, mon_e.cnt, mon_e.werr);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      int           d, ra, r;
      rst = 1'b1; br_valid = 1'b0; br_op = '0; br_target = '0;
      reg_a = '0; reg15 = '0; opnd_ready = 1'b0;
      m_cnt = 0; m_werr = 1'b0;
      @(posedge clk);
      #1;
      rst_cyc("reset");
      rst_cyc("reset");
      idle_cyc();

      branch(2'b11, 16'h1234, 16'h0005, 16'h0003, 0, -1, "gt_taken");
      branch(2'b10, 16'hABCD, 16'h0004, 16'h0003, 0, -1, "eq_nt");
      branch(2'b10, 16'h0F0F, 16'h0007, 16'h0007, 0, -1, "eq_taken");
      branch(2'b01, 16'h2222, 16'h8000, 16'h0001, 0, -1, "wrap_lt_nt");
      branch(2'b11, 16'h3333, 16'h8000, 16'h0001, 0, -1, "wrap_gt_tk");
      branch(2'b01, 16'h4444, 16'h0001, 16'h8000, 0, -1, "wrap_lt_tk");
      branch(2'b11, 16'h5555, 16'h0003, 16'h0003, 0, -1, "gt_equal_nt");
      junk(); br_valid = 1'b1; br_op = 2'b00;
      step(mk(0, 0, 0, '0), "op_none_ignored");
      branch(2'b11, 16'h6666, 16'h0009, 16'h0002, 3, -1, "opnd_wait");
      branch(2'b10, 16'h7777, 16'h0010, 16'h0010, 15, -1, "wait_max_ok");
      branch(2'b11, 16'h8888, 16'h0009, 16'h0002, 20, -1, "timeout");
      idle_cyc();
      branch(2'b11, 16'h9999, 16'h0009, 16'h0002, 5, 2, "rst_in_wait");
      branch(2'b11, 16'hAAAA, 16'h0009, 16'h0002, 0, -1, "post_rst_wait");
      branch(2'b11, 16'hBBBB, 16'h0009, 16'h0002, 0, 2, "rst_in_flush");
      branch(2'b01, 16'hCCCC, 16'h0001, 16'h0002, 0, -1, "post_rst_flush");
      branch(2'b10, 16'hDDDD, 16'h0001, 16'h0001, 0, 1, "rst_in_eval");

      for (int i = 0; i < 300; i++) begin
         op = 2'($urandom_range(1, 3));
         a  = W'($urandom);
         b  = W'($urandom);
         case ($urandom_range(0, 3))
            1: b = a;
            2: b = a + W'($urandom_range(0, 2)) - W'(1);
            3: begin a = pick_val(); b = pick_val(); end
            default: ;
         endcase
         r = $urandom_range(0, 19);
         d = (r < 12) ? 0 : (r < 18) ? $urandom_range(1, 15) : $urandom_range(16, 17);
         ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
         branch(op, W'($urandom), a, b, d, ra, "rand");
         repeat ($urandom_range(0, 2)) idle_cyc();
      end

      idle_cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
